// File: rtl/uart_wb_pkg.sv
// Shared types and constants for the UART16550 Wishbone command master.
package uart_wb_pkg;

    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 32;
    localparam int TMO_CYC_DEF = 255;
    localparam int TMO_W       = $clog2(TMO_CYC_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_e;

    typedef struct packed {
        logic                  err;
        logic [DATA_W_DEF-1:0] dat;
    } wbm_rsp_t;

    // Timer width for a given timeout, so overridden TMO_CYC values size correctly.
    function automatic int tmo_width(input int cyc);
        return $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/uart_int_sync.sv
// Brings the UART interrupt line into the clock domain and turns rising
// edges into a sticky pending flag that software clears with irq_clr.
module uart_int_sync (
    input  logic clk,
    input  logic rst,
    input  logic int_i,
    input  logic irq_clr,
    output logic irq_pending
);

    logic sync1_q, sync2_q, prev_q, pend_q;
    logic pend_d, edge_w;

    assign edge_w = sync2_q & ~prev_q;

    // A new edge beats a clear arriving in the same cycle.
    always_comb begin
        pend_d = pend_q;
        if (irq_clr) pend_d = 1'b0;
        if (edge_w)  pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sync1_q <= int_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pend_q  <= pend_d;
        end
    end

    assign irq_pending = pend_q;

endmodule

// File: rtl/uart_wb_master.sv
// Single-beat Wishbone classic initiator for the UART16550 register port:
// one command in, one bus cycle, one response out, with an ack timeout.
module uart_wb_master
    import uart_wb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_adr,
    input  logic [DATA_W-1:0] cmd_dat,
    input  logic [3:0]        cmd_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_dat,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    output logic [3:0]        wb_sel_o,
    input  logic              wb_ack_i,
    input  logic              int_i,
    input  logic              irq_clr,
    output logic              irq_pending,
    output logic              busy,
    output wbm_state_e        dbg_state_o
);

    localparam int TW = tmo_width(TMO_CYC);

    wbm_state_e        state_q;
    logic              cmd_ready_q, busy_q, rsp_valid_q;
    logic              wb_we_q, wb_cyc_q, wb_stb_q;
    logic [ADDR_W-1:0] wb_adr_q;
    logic [DATA_W-1:0] wb_dat_q;
    logic [3:0]        wb_sel_q;
    wbm_rsp_t          rsp_q;
    logic [TW-1:0]     timer_q, timer_d;

    assign timer_d = timer_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            wb_we_q     <= 1'b0;
            wb_cyc_q    <= 1'b0;
            wb_stb_q    <= 1'b0;
            wb_adr_q    <= '0;
            wb_dat_q    <= '0;
            wb_sel_q    <= '0;
            timer_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        wb_adr_q    <= cmd_adr;
                        wb_dat_q    <= cmd_dat;
                        wb_we_q     <= cmd_we;
                        wb_sel_q    <= cmd_sel;
                        wb_cyc_q    <= 1'b1;
                        wb_stb_q    <= 1'b1;
                        timer_q     <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= BUS;
                    end
                end
                BUS: begin
                    // An ack on the timeout edge still completes the cycle normally.
                    if (wb_ack_i) begin
                        wb_cyc_q    <= 1'b0;
                        wb_stb_q    <= 1'b0;
                        rsp_q.err   <= 1'b0;
                        rsp_q.dat   <= wb_we_q ? '0 : wb_dat_i;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (timer_q == TW'(TMO_CYC - 1)) begin
                        wb_cyc_q    <= 1'b0;
                        wb_stb_q    <= 1'b0;
                        rsp_q.err   <= 1'b1;
                        rsp_q.dat   <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    uart_int_sync u_int_sync (
        .clk         (clk),
        .rst         (rst),
        .int_i       (int_i),
        .irq_clr     (irq_clr),
        .irq_pending (irq_pending)
    );

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_dat     = rsp_q.dat;
    assign rsp_err     = rsp_q.err;
    assign wb_adr_o    = wb_adr_q;
    assign wb_dat_o    = wb_dat_q;
    assign wb_we_o     = wb_we_q;
    assign wb_stb_o    = wb_stb_q;
    assign wb_cyc_o    = wb_cyc_q;
    assign wb_sel_o    = wb_sel_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: directed corner cases plus random commands against
// a memory-backed slave, responses checked by a scoreboard monitor.
module tb_uart_wb_master;
    import uart_wb_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [4:0]  cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
    logic [3:0]  wb_sel_o;
    logic        int_i, irq_clr, irq_pending, busy;
    wbm_state_e  dbg_state;

    always #5 clk = ~clk;

    uart_wb_master #(.ADDR_W(5), .DATA_W(32), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i),
        .int_i(int_i), .irq_clr(irq_clr), .irq_pending(irq_pending),
        .busy(busy), .dbg_state_o(dbg_state)
    );

    int          errors = 0;
    int          checks = 0;
    logic [32:0] exp_q[$];
    logic [31:0] ref_mem[32];
    logic [31:0] slave_mem[32];
    int          ack_at = 0;
    int          last_len = 0;
    logic        stray_ack = 1'b0;
    logic        bp_hold = 1'b0;
    logic [4:0]  exp_adr = '0;
    logic [31:0] exp_dat = '0;
    logic        exp_we = 1'b0;
    logic [3:0]  exp_sel = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave: acks on the ack_at-th strobe cycle (0 = never); byte-enabled memory.
    initial begin
        int   cnt;
        logic armed;
        cnt = 0;
        armed = 1'b0;
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(negedge clk);
            if (armed) begin
                check("rsp_valid_after_ack", rsp_valid, 1);
                check("stb_drop_after_ack", wb_stb_o, 0);
                armed = 1'b0;
            end
            if (wb_cyc_o && wb_stb_o) begin
                cnt++;
                check("wb_req_stable", {wb_we_o, wb_sel_o, wb_adr_o}, {exp_we, exp_sel, exp_adr});
                check("wb_dat_o", wb_dat_o, exp_dat);
                if (cnt == ack_at) begin
                    wb_ack_i = 1'b1;
                    if (wb_we_o) begin
                        for (int b = 0; b < 4; b++)
                            if (wb_sel_o[b]) slave_mem[wb_adr_o][8*b +: 8] = wb_dat_o[8*b +: 8];
                        wb_dat_i = $urandom;
                    end else begin
                        wb_dat_i = slave_mem[wb_adr_o];
                    end
                    armed = 1'b1;
                end else begin
                    wb_ack_i = 1'b0;
                    wb_dat_i = $urandom;
                end
            end else begin
                if (cnt != 0) last_len = cnt;
                cnt = 0;
                wb_ack_i = stray_ack;
                wb_dat_i = $urandom;
            end
        end
    end

    // Monitor: drives rsp_ready and pops the scoreboard on each handshake.
    initial begin
        logic [32:0] e;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got err=%0b dat=%h expected no response", rsp_err, rsp_dat);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_err", rsp_err, e[32]);
                    check("rsp_dat", rsp_dat, e[31:0]);
                end
            end
        end
    end

    task automatic do_cmd(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int ack_k);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", cmd_ready, 1);
            return;
        end
        ack_at  = ack_k;
        exp_we  = we;
        exp_adr = adr;
        exp_dat = dat;
        exp_sel = sel;
        if (ack_k >= 1 && ack_k <= TMO) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[adr][8*b +: 8] = dat[8*b +: 8];
                exp_q.push_back({1'b0, 32'h0});
            end else begin
                exp_q.push_back({1'b0, ref_mem[adr]});
            end
        end else begin
            exp_q.push_back({1'b1, 32'h0});
        end
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", exp_q.size() == 0 && !busy, 1);
    endtask

    initial begin
        logic [32:0] e;
        int          n;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        int_i     = 1'b0;
        irq_clr   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ref_mem[i]   = $urandom;
            slave_mem[i] = ref_mem[i];
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp", {rsp_err, rsp_dat[30:0]}, 0);
        check("reset_cyc_stb", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        check("reset_wb_adr_dat", wb_adr_o | wb_dat_o | wb_sel_o, 0);
        check("reset_irq", irq_pending, 0);
        check("reset_busy", busy, 0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b1;

        // Stray ack while idle must not move the FSM.
        @(posedge clk); #1 stray_ack = 1'b1;
        @(posedge clk); #1 stray_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("stray_ack_busy", busy, 0);
        check("stray_ack_rsp", rsp_valid, 0);
        check("stray_ack_ready", cmd_ready, 1);

        do_cmd(1'b1, 5'h03, 32'h83, 4'h1, 3);
        wait_drain();
        check("write_stb_len", last_len, 3);

        ref_mem[5] = 32'h60;
        slave_mem[5] = 32'h60;
        do_cmd(1'b0, 5'h05, $urandom, 4'hf, 1);
        wait_drain();
        check("zero_wait_stb_len", last_len, 1);

        do_cmd(1'b0, 5'h09, $urandom, 4'hf, 0);
        wait_drain();
        check("timeout_stb_len", last_len, TMO);
        do_cmd(1'b0, 5'h0a, $urandom, 4'hf, TMO);
        wait_drain();
        check("ack_at_timeout_len", last_len, TMO);
        do_cmd(1'b1, 5'h0b, $urandom, 4'hf, TMO + 1);
        wait_drain();

        // Backpressure: response held, no new command accepted.
        @(posedge clk); #1 bp_hold = 1'b1;
        do_cmd(1'b0, 5'h0c, $urandom, 4'h3, 2);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_queue_depth", exp_q.size(), 1);
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        repeat (10) begin
            @(negedge clk);
            check("bp_hold_rsp", {rsp_valid, rsp_err}, {1'b1, e[32]});
            check("bp_hold_dat", rsp_dat, e[31:0]);
            check("bp_no_cmd", {cmd_ready, wb_cyc_o, wb_stb_o}, 0);
        end
        @(posedge clk); #1 bp_hold = 1'b0;
        wait_drain();

        // Reset during a bus cycle discards the transaction.
        do_cmd(1'b0, 5'h0d, $urandom, 4'hf, 0);
        @(negedge clk);
        check("pre_reset_stb", wb_stb_o, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_cyc_stb", {wb_cyc_o, wb_stb_o}, 0);
        check("mid_reset_rsp_valid", rsp_valid, 0);
        check("mid_reset_cmd_ready", cmd_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;

        // Interrupt synchronizer and sticky flag.
        @(negedge clk);
        int_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("irq_not_yet", irq_pending, 0);
        @(negedge clk);
        check("irq_after_3_edges", irq_pending, 1);
        repeat (5) @(negedge clk);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("irq_cleared", irq_pending, 0);
        repeat (10) @(negedge clk);
        check("irq_level_no_reset", irq_pending, 0);
        int_i = 1'b0;
        repeat (4) @(negedge clk);
        check("irq_fall_no_set", irq_pending, 0);
        int_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("irq_set_beats_clr", irq_pending, 1);
        @(negedge clk);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("irq_clr_again", irq_pending, 0);
        int_i = 1'b0;

        for (int i = 0; i < 40; i++) begin
            do_cmd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                   4'($urandom_range(0, 15)), $urandom_range(0, 6));
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
